rv32i_decode_queue: RTL
=======================

// Module: rv32i_decode_queue
// PURPOSE
//  Decode stage with elastic instruction buffering: accepts {pc,inst} pairs from fetch over valid/ready,
//  holds up to DEPTH undecoded instructions, and presents one registered decoded bundle to execute
//  over valid/ready. Replaces enable/stall chaining with a back-pressure handshake; adds optional RV32M decode.
// PARAMETERS
//  DEPTH     2   raw instruction queue entries (power of 2, >=2)
//  PC_W      32  program-counter width
//  CNT_W     $clog2(DEPTH+1)  occupancy width (derived, not overridable)
// PORTS
//  i_clk        in   1         clock
//  i_rst_n      in   1         async reset, active low
//  i_valid      in   1         fetch offers i_pc/i_inst
//  o_ready      out  1         queue can accept (count < DEPTH)
//  i_pc         in   PC_W      PC of offered instruction
//  i_inst       in   32        offered instruction word
//  o_valid      out  1         decoded bundle valid
//  i_ready      in   1         execute consumes bundle this cycle
//  o_pc         out  PC_W      PC of bundle
//  o_rs1_addr   out  5         inst[19:15]
//  o_rs2_addr   out  5         inst[24:20]
//  o_rd_addr    out  5         inst[11:7]
//  o_funct3     out  3         inst[14:12]
//  o_imm        out  32        sign/zero-extended immediate per opcode class
//  o_alu        out  ALU_W     one-hot ALU op (ALU_W from package; grows with RV32M_EN)
//  o_opcode     out  OPC_W     one-hot opcode class (RTYPE..FENCE, 11 bits)
//  o_exception  out  4         {MRET,EBREAK,ECALL,ILLEGAL}
//  i_flush      in   1         discard all buffered and presented instructions
//  o_count      out  CNT_W     queue occupancy (excludes output register)
// BEHAVIOUR
//  - Reset: o_valid=0, count=0, o_ready=1, all bundle fields 0, rd/wr pointers 0.
//  - Accept on i_valid&&o_ready; consume on o_valid&&i_ready. o_ready is a function of count only,
//    never of i_ready or i_valid (no combinational path fetch<->execute).
//  - Output register loads when slot free (!o_valid || i_ready): source is queue head if count>0,
//    else incoming accepted instruction (bypass). Bypass latency 1 cycle; strict program order always.
//  - Decoding is combinational on the selected source, registered into the bundle; bundle stable while
//    o_valid && !i_ready.
//  - Simultaneous accept+consume at count==DEPTH: not accepted (o_ready=0); count drops next cycle.
//  - Simultaneous accept+head-pop: count unchanged; pointers wrap modulo DEPTH.
//  - i_flush: next edge count=0, pointers=0, o_valid=0; same-cycle input and consume are discarded;
//    flush wins over every other event. Bundle data fields hold (don't-care when !o_valid).
//  - Imm: I/LOAD/JALR sext inst[31:20]; STORE sext{[31:25],[11:7]}; BRANCH sext B-imm<<1; JAL sext J-imm<<1;
//    LUI/AUIPC {[31:12],12'h0}; SYSTEM/FENCE zext [31:20]; else 0.
//  - ALU: R add/sub by inst[30]; I add only; srl/sra by inst[30]; BRANCH eq/neq/lt/ge/ltu/geu; others ADD.
//  - ILLEGAL: unknown opcode, or I-type shift with inst[25]=1, or R-type funct7 not in {0x00,0x20}
//    (0x20 only with funct3 ADD/SRA). ECALL/EBREAK/MRET: SYSTEM, funct3=0, inst[21:20]=00/01/10.
//  - Exceptional instructions still flow as normal bundles; no local state change.
//  - Async reset mid-transfer: all in-flight instructions lost, outputs to reset values immediately.
// CONFIGURATION
//  RV32I_DECODE_M_EN defined: R-type funct7=0x01 decodes MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU
//   into 8 extra o_alu bits (ALU_W=22), not ILLEGAL.
//  Undefined: ALU_W=14; funct7=0x01 R-type sets ILLEGAL, o_alu all zero.
// STRUCTURE
//  rv32i_pkg: opcode/funct3/funct7 constants, ALU/OPCODE/EXCEPTION bit indices, ALU_W, OPC_W,
//   decoded-bundle struct typedef.
//  Sub-module rv32i_decode_logic: pure combinational inst -> {imm,alu,opcode,exception}; instantiated once
//   on the bypass/head mux output. Queue (regfile+pointers+count) and output register live in top.
// TESTING
//  1 Empty queue, i_ready=1, ADDI x1,x0,5 (0x00500093) -> o_valid next cycle, imm=5, alu ADD, ITYPE, count=0.
//  2 i_ready=0, stream 4 instrs, DEPTH=2 -> 1 in output reg, count=2, o_ready=0; release -> order preserved.
//  3 Full queue + i_flush with i_valid=1 -> next cycle o_valid=0, count=0, o_ready=1; flushed inst never seen.
//  4 SLLI with inst[25]=1 (0x02009093) -> ILLEGAL=1; 0x00000073 -> ECALL; 0x30200073 -> MRET; 0xFFFFFFFF -> ILLEGAL.
//  5 MUL x3,x1,x2 (0x022081B3): with RV32I_DECODE_M_EN alu MUL=1 ILLEGAL=0; without, ILLEGAL=1.
//  6 Random valid/ready/flush 10k cycles vs reference model: no loss, no dup, order kept, count<=DEPTH.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I decode constants, one-hot bit indices and the decoded-bundle type.
// Define RV32I_DECODE_M_EN to widen o_alu with the RV32M multiply/divide ops.
package rv32i_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    localparam logic [6:0] F7_BASE   = 7'h00;
    localparam logic [6:0] F7_ALT    = 7'h20;
    localparam logic [6:0] F7_MULDIV = 7'h01;

    localparam int unsigned OPC_RTYPE  = 0;
    localparam int unsigned OPC_ITYPE  = 1;
    localparam int unsigned OPC_LOAD   = 2;
    localparam int unsigned OPC_STORE  = 3;
    localparam int unsigned OPC_BRANCH = 4;
    localparam int unsigned OPC_JAL    = 5;
    localparam int unsigned OPC_JALR   = 6;
    localparam int unsigned OPC_LUI    = 7;
    localparam int unsigned OPC_AUIPC  = 8;
    localparam int unsigned OPC_SYSTEM = 9;
    localparam int unsigned OPC_FENCE  = 10;
    localparam int unsigned OPC_W      = 11;

    localparam int unsigned ALU_ADD  = 0;
    localparam int unsigned ALU_SUB  = 1;
    localparam int unsigned ALU_SLT  = 2;
    localparam int unsigned ALU_SLTU = 3;
    localparam int unsigned ALU_XOR  = 4;
    localparam int unsigned ALU_OR   = 5;
    localparam int unsigned ALU_AND  = 6;
    localparam int unsigned ALU_SLL  = 7;
    localparam int unsigned ALU_SRL  = 8;
    localparam int unsigned ALU_SRA  = 9;
    localparam int unsigned ALU_EQ   = 10;
    localparam int unsigned ALU_NEQ  = 11;
    localparam int unsigned ALU_GE   = 12;
    localparam int unsigned ALU_GEU  = 13;
    // MUL..REMU occupy ALU_MUL + funct3
    localparam int unsigned ALU_MUL  = 14;

`ifdef RV32I_DECODE_M_EN
    localparam int unsigned ALU_W = 22;
`else
    localparam int unsigned ALU_W = 14;
`endif

    localparam int unsigned EXC_ILLEGAL = 0;
    localparam int unsigned EXC_ECALL   = 1;
    localparam int unsigned EXC_EBREAK  = 2;
    localparam int unsigned EXC_MRET    = 3;
    localparam int unsigned EXC_W       = 4;

    typedef struct packed {
        logic [31:0]      imm;
        logic [ALU_W-1:0] alu;
        logic [OPC_W-1:0] opcode;
        logic [EXC_W-1:0] exception;
    } decoded_t;

    function automatic logic [ALU_W-1:0] alu_base(input logic [2:0] f3, input logic alt);
        logic [ALU_W-1:0] a;
        a = '0;
        case (f3)
            F3_ADD:  a[alt ? ALU_SUB : ALU_ADD] = 1'b1;
            F3_SLL:  a[ALU_SLL] = 1'b1;
            F3_SLT:  a[ALU_SLT] = 1'b1;
            F3_SLTU: a[ALU_SLTU] = 1'b1;
            F3_XOR:  a[ALU_XOR] = 1'b1;
            F3_SR:   a[alt ? ALU_SRA : ALU_SRL] = 1'b1;
            F3_OR:   a[ALU_OR] = 1'b1;
            default: a[ALU_AND] = 1'b1;
        endcase
        return a;
    endfunction

    function automatic logic [ALU_W-1:0] alu_branch(input logic [2:0] f3);
        logic [ALU_W-1:0] a;
        a = '0;
        case (f3)
            F3_BEQ:  a[ALU_EQ] = 1'b1;
            F3_BNE:  a[ALU_NEQ] = 1'b1;
            F3_BLT:  a[ALU_SLT] = 1'b1;
            F3_BGE:  a[ALU_GE] = 1'b1;
            F3_BLTU: a[ALU_SLTU] = 1'b1;
            F3_BGEU: a[ALU_GEU] = 1'b1;
            default: a[ALU_ADD] = 1'b1;
        endcase
        return a;
    endfunction

`ifdef RV32I_DECODE_M_EN
    function automatic logic [ALU_W-1:0] alu_muldiv(input logic [2:0] f3);
        logic [ALU_W-1:0] a;
        a = '0;
        a[ALU_MUL] = 1'b1;
        return a << f3;
    endfunction
`endif

endpackage

// File: rtl/rv32i_decode_logic.sv
// Pure combinational RV32I decoder: instruction word -> immediate, ALU op, opcode class, exceptions.
// RV32I_DECODE_M_EN enables decoding of funct7=0x01 R-type as RV32M.
module rv32i_decode_logic
    import rv32i_pkg::*;
(
    input  logic [31:0] i_inst,
    output decoded_t    o_dec
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_j;
    logic [31:0] imm_u;
    logic [31:0] imm_z;
    logic        r_base_ok;

    assign opcode = i_inst[6:0];
    assign funct3 = i_inst[14:12];
    assign funct7 = i_inst[31:25];

    assign imm_i = {{20{i_inst[31]}}, i_inst[31:20]};
    assign imm_s = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
    assign imm_b = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
    assign imm_j = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
    assign imm_u = {i_inst[31:12], 12'h000};
    assign imm_z = {20'h00000, i_inst[31:20]};

    // funct7=0x20 is only meaningful for SUB and SRA
    assign r_base_ok = (funct7 == F7_BASE) ||
                       (funct7 == F7_ALT && (funct3 == F3_ADD || funct3 == F3_SR));

    always_comb begin
        o_dec = '0;
        o_dec.alu[ALU_ADD] = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                o_dec.opcode[OPC_RTYPE] = 1'b1;
                if (r_base_ok) begin
                    o_dec.alu = alu_base(funct3, i_inst[30]);
                end
`ifdef RV32I_DECODE_M_EN
                else if (funct7 == F7_MULDIV) begin
                    o_dec.alu = alu_muldiv(funct3);
                end
`endif
                else begin
                    o_dec.alu = '0;
                    o_dec.exception[EXC_ILLEGAL] = 1'b1;
                end
            end
            OP_ITYPE: begin
                o_dec.opcode[OPC_ITYPE] = 1'b1;
                o_dec.imm = imm_i;
                o_dec.alu = alu_base(funct3, (funct3 == F3_SR) && i_inst[30]);
                if ((funct3 == F3_SLL || funct3 == F3_SR) && i_inst[25]) begin
                    o_dec.exception[EXC_ILLEGAL] = 1'b1;
                end
            end
            OP_LOAD: begin
                o_dec.opcode[OPC_LOAD] = 1'b1;
                o_dec.imm = imm_i;
            end
            OP_STORE: begin
                o_dec.opcode[OPC_STORE] = 1'b1;
                o_dec.imm = imm_s;
            end
            OP_BRANCH: begin
                o_dec.opcode[OPC_BRANCH] = 1'b1;
                o_dec.imm = imm_b;
                o_dec.alu = alu_branch(funct3);
            end
            OP_JAL: begin
                o_dec.opcode[OPC_JAL] = 1'b1;
                o_dec.imm = imm_j;
            end
            OP_JALR: begin
                o_dec.opcode[OPC_JALR] = 1'b1;
                o_dec.imm = imm_i;
            end
            OP_LUI: begin
                o_dec.opcode[OPC_LUI] = 1'b1;
                o_dec.imm = imm_u;
            end
            OP_AUIPC: begin
                o_dec.opcode[OPC_AUIPC] = 1'b1;
                o_dec.imm = imm_u;
            end
            OP_SYSTEM: begin
                o_dec.opcode[OPC_SYSTEM] = 1'b1;
                o_dec.imm = imm_z;
                if (funct3 == 3'd0) begin
                    case (i_inst[21:20])
                        2'b00:   o_dec.exception[EXC_ECALL] = 1'b1;
                        2'b01:   o_dec.exception[EXC_EBREAK] = 1'b1;
                        2'b10:   o_dec.exception[EXC_MRET] = 1'b1;
                        default: ;
                    endcase
                end
            end
            OP_FENCE: begin
                o_dec.opcode[OPC_FENCE] = 1'b1;
                o_dec.imm = imm_z;
            end
            default: o_dec.exception[EXC_ILLEGAL] = 1'b1;
        endcase
    end

endmodule

// File: rtl/rv32i_decode_queue.sv
// Elastic decode stage: DEPTH-entry raw instruction queue feeding one registered decoded bundle.
// Build with RV32I_DECODE_M_EN defined to add RV32M decode (o_alu grows to 22 bits).
module rv32i_decode_queue
    import rv32i_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned PC_W  = 32,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [PC_W-1:0]  i_pc,
    input  logic [31:0]      i_inst,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [PC_W-1:0]  o_pc,
    output logic [4:0]       o_rs1_addr,
    output logic [4:0]       o_rs2_addr,
    output logic [4:0]       o_rd_addr,
    output logic [2:0]       o_funct3,
    output logic [31:0]      o_imm,
    output logic [ALU_W-1:0] o_alu,
    output logic [OPC_W-1:0] o_opcode,
    output logic [3:0]       o_exception,
    input  logic             i_flush,
    output logic [CNT_W-1:0] o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PC_W-1:0]  mem_pc_q   [DEPTH];
    logic [31:0]      mem_inst_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    logic             valid_q;
    logic [PC_W-1:0]  pc_q;
    logic [31:0]      inst_q;
    decoded_t         dec_q;

    logic             accept;
    logic             slot_free;
    logic             q_nonempty;
    logic             pop;
    logic             bypass;
    logic             push;
    logic             load;
    logic [PC_W-1:0]  src_pc;
    logic [31:0]      src_inst;
    decoded_t         src_dec;

    // Ready depends on occupancy alone so fetch and execute never share a combinational path
    assign o_ready    = (count_q != CNT_W'(DEPTH));
    assign accept     = i_valid && o_ready;
    assign slot_free  = !valid_q || i_ready;
    assign q_nonempty = (count_q != '0);
    assign pop        = slot_free && q_nonempty;
    assign bypass     = slot_free && !q_nonempty && accept;
    assign push       = accept && !bypass;
    assign load       = pop || bypass;
    assign src_pc     = q_nonempty ? mem_pc_q[rd_ptr_q] : i_pc;
    assign src_inst   = q_nonempty ? mem_inst_q[rd_ptr_q] : i_inst;

    rv32i_decode_logic u_decode (
        .i_inst (src_inst),
        .o_dec  (src_dec)
    );

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_pc_q[wr_ptr_q]   <= i_pc;
            mem_inst_q[wr_ptr_q] <= i_inst;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            pc_q     <= '0;
            inst_q   <= '0;
            dec_q    <= '0;
        end else if (i_flush) begin
            // Bundle data is left as-is; it is meaningless once valid drops
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            if (load) begin
                valid_q <= 1'b1;
                pc_q    <= src_pc;
                inst_q  <= src_inst;
                dec_q   <= src_dec;
            end else if (slot_free) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign o_valid     = valid_q;
    assign o_pc        = pc_q;
    assign o_rs1_addr  = inst_q[19:15];
    assign o_rs2_addr  = inst_q[24:20];
    assign o_rd_addr   = inst_q[11:7];
    assign o_funct3    = inst_q[14:12];
    assign o_imm       = dec_q.imm;
    assign o_alu       = dec_q.alu;
    assign o_opcode    = dec_q.opcode;
    assign o_exception = dec_q.exception;
    assign o_count     = count_q;

endmodule
